prog_seq: RTL and testbench

- Parametrised program sequencer; the next-generation program counter for the 3BC processor core.
- Adds over the plain PC:
  - run-control FSM (IDLE/RUN/DONE) with Start, Halt and Stall inputs
  - relative or absolute branch targets
  - hardware call/return stack of configurable depth
  - sticky stack-error flag
- Feeds instruction ROM address; control inputs come from the decoder in the same cycle.

---
 rtl/prog_seq.sv | 137 +++++++++++++
 tb/tb_prog_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq.sv
// prog_seq: program sequencer for the 3BC core.
// Run-control FSM (IDLE/RUN/DONE), relative/absolute branches, a hardware
// call/return stack and a sticky stack-error flag. Every output comes from a
// register or is decoded directly from registered state.
module prog_seq #(
  parameter int              PC_W        = 10,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] START_ADDR  = '0
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Start,
  input  logic                               Halt,
  input  logic                               Stall,
  input  logic                               BranchEn,
  input  logic                               BranchAbs,
  input  logic                               Call,
  input  logic                               Ret,
  input  logic [PC_W-1:0]                    Target,
  output logic [PC_W-1:0]                    ProgCtr,
  output logic                               Running,
  output logic                               Done,
  output logic                               StackErr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   Depth
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            push_en;

  logic [PC_W-1:0] stack_q [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] dest;
  logic [PC_W-1:0] top;
  logic            stack_full;

  // Shared datapath: all additions wrap modulo 2^PC_W by truncation, so a
  // two's-complement Target yields a backward branch.
  assign pc_inc     = pc_q + PC_W'(1);
  assign dest       = BranchAbs ? Target : pc_q + Target;
  assign top        = stack_q[IW'(depth_q - DW'(1))];
  assign stack_full = (depth_q == DW'(STACK_DEPTH));

  // Next-state logic: run control plus the single prioritised action per RUN cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    depth_d = depth_q;
    push_en = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          depth_d = '0;
          err_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (Stall) begin
          // Freeze: PC, stack and flags all hold.
        end else if (Halt) begin
          state_d = S_DONE;
        end else if (Ret) begin
          if (depth_q != '0) begin
            pc_d    = top;
            depth_d = depth_q - DW'(1);
          end else begin
            err_d = 1'b1;
            pc_d  = pc_inc;
          end
        end else if (Call) begin
          pc_d = dest;
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DW'(1);
          end
        end else if (BranchEn) begin
          pc_d = dest;
        end else begin
          pc_d = pc_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and PC registers; synchronous Reset overrides everything.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      err_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      depth_q <= depth_d;
    end
  end

  // Return-address storage; the entry above the current top receives PC+1.
  always_ff @(posedge Clk) begin
    // NOTE: the stack array is deliberately not reset; Depth alone marks valid entries.
    if (!Reset && push_en) begin
      stack_q[IW'(depth_q)] <= pc_inc;
    end
  end

  assign ProgCtr  = pc_q;
  assign Running  = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign StackErr = err_q;
  assign Depth    = depth_q;

endmodule

// File: tb/tb_prog_seq.sv
// Testbench for prog_seq: a directed vector table with hand-computed expected
// values, followed by randomized stimulus checked against a queue-based
// behavioural model.
module tb_prog_seq;

  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int PC_M  = 1 << PC_W;

  // Control bits packed into one word for the vector table.
  localparam int R = 1;    // Reset
  localparam int S = 2;    // Start
  localparam int H = 4;    // Halt
  localparam int L = 8;    // Stall
  localparam int B = 16;   // BranchEn
  localparam int A = 32;   // BranchAbs
  localparam int C = 64;   // Call
  localparam int T = 128;  // Ret

  logic            Clk = 1'b0;
  logic            Reset = 1'b0, Start = 1'b0, Halt = 1'b0, Stall = 1'b0;
  logic            BranchEn = 1'b0, BranchAbs = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [PC_W-1:0] Target = '0;
  logic [PC_W-1:0] ProgCtr;
  logic            Running, Done, StackErr;
  logic [2:0]      Depth;

  prog_seq #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .START_ADDR('0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
    .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Call(Call), .Ret(Ret),
    .Target(Target), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .StackErr(StackErr), .Depth(Depth)
  );

  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_state = 0;       // 0 idle, 1 run, 2 done
  int m_pc    = 0;
  int m_err   = 0;
  int m_stk[$];

  function automatic void model_step();
    int d;
    d = BranchAbs ? int'(Target) : (m_pc + int'(Target)) % PC_M;
    if (Reset) begin
      m_state = 0; m_pc = 0; m_err = 0; m_stk.delete();
    end else if (m_state != 1) begin
      if (Start) begin
        m_state = 1; m_pc = 0; m_err = 0; m_stk.delete();
      end
    end else if (Stall) begin
      // nothing moves
    end else if (Halt) begin
      m_state = 2;
    end else if (Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_err = 1; m_pc = (m_pc + 1) % PC_M; end
    end else if (Call) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PC_M);
      else m_err = 1;
      m_pc = d;
    end else if (BranchEn) begin
      m_pc = d;
    end else begin
      m_pc = (m_pc + 1) % PC_M;
    end
  endfunction

  task automatic set_in(input int ctl, input int tgt);
    Reset     = ctl[0];
    Start     = ctl[1];
    Halt      = ctl[2];
    Stall     = ctl[3];
    BranchEn  = ctl[4];
    BranchAbs = ctl[5];
    Call      = ctl[6];
    Ret       = ctl[7];
    Target    = PC_W'(tgt);
  endtask

  // One clock: advance the model, clock the DUT, sample 1 ns after the edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    check({tag, " pc"},    int'(ProgCtr),  m_pc);
    check({tag, " run"},   int'(Running),  int'(m_state == 1));
    check({tag, " done"},  int'(Done),     int'(m_state == 2));
    check({tag, " err"},   int'(StackErr), m_err);
    check({tag, " depth"}, int'(Depth),    m_stk.size());
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int ctl;
    int tgt;
    int pc;
    int run;
    int dn;
    int err;
    int dep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int ctl, input int tgt, input int pc,
                              input int run, input int dn, input int err, input int dep);
    vec_t v;
    v.ctl = ctl; v.tgt = tgt; v.pc = pc; v.run = run; v.dn = dn; v.err = err; v.dep = dep;
    vecs.push_back(v);
  endfunction

  initial begin
    // reset, start, plain increments, halt and DONE ignoring inputs
    add(R, 0, 0, 0, 0, 0, 0);
    add(S, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 2, 1, 0, 0, 0);
    add(0, 0, 3, 1, 0, 0, 0);
    add(0, 0, 4, 1, 0, 0, 0);
    add(H, 0, 4, 0, 1, 0, 0);
    add(H | C | A, 50, 4, 0, 1, 0, 0);
    add(B | A, 60, 4, 0, 1, 0, 0);
    add(0, 0, 4, 0, 1, 0, 0);
    add(S, 0, 0, 1, 0, 0, 0);
    add(S, 0, 1, 1, 0, 0, 0);                 // Start in RUN ignored
    // relative and absolute branches
    add(B | A, 10, 10, 1, 0, 0, 0);
    add(B, 'h3FE, 8, 1, 0, 0, 0);
    add(B | A, 100, 100, 1, 0, 0, 0);
    // call / return
    add(B | A, 20, 20, 1, 0, 0, 0);
    add(C | A, 200, 200, 1, 0, 0, 1);
    add(0, 0, 201, 1, 0, 0, 1);
    add(0, 0, 202, 1, 0, 0, 1);
    add(0, 0, 203, 1, 0, 0, 1);
    add(T, 0, 21, 1, 0, 0, 0);
    // nested calls to overflow, then unwind to underflow
    add(C | A, 300, 300, 1, 0, 0, 1);
    add(C | A, 400, 400, 1, 0, 0, 2);
    add(C, 5, 405, 1, 0, 0, 3);
    add(C | A, 500, 500, 1, 0, 0, 4);
    add(C | A, 600, 600, 1, 0, 1, 4);
    add(T, 0, 406, 1, 0, 1, 3);
    add(T, 0, 401, 1, 0, 1, 2);
    add(T, 0, 301, 1, 0, 1, 1);
    add(T, 0, 22, 1, 0, 1, 0);
    add(T, 0, 23, 1, 0, 1, 0);
    // stall priority, PC wrap
    add(L | C | A, 77, 23, 1, 0, 1, 0);
    add(L | H, 0, 23, 1, 0, 1, 0);
    add(B | A, 1023, 1023, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    // reset mid-run with Call, IDLE ignores inputs
    add(C | A, 50, 50, 1, 0, 1, 1);
    add(R | C | A, 90, 0, 0, 0, 0, 0);
    add(C | B | T | H, 5, 0, 0, 0, 0, 0);
    // Start from DONE clears StackErr and Depth
    add(S, 0, 0, 1, 0, 0, 0);
    add(C | A, 7, 7, 1, 0, 0, 1);
    add(T, 0, 1, 1, 0, 0, 0);
    add(T, 0, 2, 1, 0, 1, 0);
    add(C | A, 9, 9, 1, 0, 1, 1);
    add(H | T, 0, 9, 0, 1, 1, 1);              // Halt beats Ret
    add(S, 0, 0, 1, 0, 0, 0);

    set_in(0, 0);
    @(posedge Clk);
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_in(vecs[i].ctl, vecs[i].tgt);
      cycle({tag, " model"});
      check({tag, " pc"},    int'(ProgCtr),  vecs[i].pc);
      check({tag, " run"},   int'(Running),  vecs[i].run);
      check({tag, " done"},  int'(Done),     vecs[i].dn);
      check({tag, " err"},   int'(StackErr), vecs[i].err);
      check({tag, " depth"}, int'(Depth),    vecs[i].dep);
    end

    // ---------------- randomized phase ----------------
    for (int n = 0; n < 4000; n++) begin
      int ctl;
      int tgt;
      bit call_heavy;
      call_heavy = ((n / 400) % 2) == 0;
      ctl = 0;
      if ($urandom_range(0, 199) == 0) ctl |= R;
      if ($urandom_range(0, 3) == 0)   ctl |= S;
      if ($urandom_range(0, 24) == 0)  ctl |= H;
      if ($urandom_range(0, 5) == 0)   ctl |= L;
      if ($urandom_range(0, 2) == 0)   ctl |= B;
      if ($urandom_range(0, 1) == 0)   ctl |= A;
      if ($urandom_range(0, call_heavy ? 1 : 4) == 0) ctl |= C;
      if ($urandom_range(0, call_heavy ? 5 : 2) == 0) ctl |= T;
      tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023))
                                        : int'($urandom_range(0, 1023));
      set_in(ctl, tgt);
      cycle($sformatf("rnd%0d", n));
    end

    set_in(0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
